// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetcher and the
// load/store unit. Exactly one transaction is in flight (IDLE -> ADDR -> RESP).
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration;
// without it data has fixed priority over instruction.
module mem_arbiter #(
  parameter int unsigned bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [bits-1:0] i_addr,
  input  logic            i_flush,
  output logic            i_rdy,
  output logic            i_valid,
  output logic [bits-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [bits-1:0] d_addr,
  input  logic [bits-1:0] d_wdata,
  output logic            d_rdy,
  output logic            d_valid,
  output logic [bits-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [bits-1:0] m_addr,
  output logic [bits-1:0] m_wdata,
  input  logic            m_rdy,
  input  logic            m_valid,
  input  logic [bits-1:0] m_rdata,
  output logic            owner,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e state_q, state_d;
  logic   drop_q;     // pending fetch response is to be discarded
  logic   grant;      // 1 = data wins, 0 = instruction wins
  logic   flush_hit;

`ifdef MEM_ARB_RR_EN
  logic last_q;       // last granted requester, 1 = data

  // Round-robin: on a tie, the requester not granted last time wins
  always_comb begin
    grant = d_req & (~i_req | ~last_q);
  end
`else
  // Fixed priority: data over instruction
  always_comb begin
    grant = d_req;
  end
`endif

  assign flush_hit = i_flush & ~owner & (state_q != StIdle);

  // Memory-side handshake and per-requester ready are purely combinational
  assign m_req = (state_q == StAddr);
  assign i_rdy = (state_q == StAddr) & m_rdy & ~owner;
  assign d_rdy = (state_q == StAddr) & m_rdy & owner;
  assign busy  = (state_q != StIdle);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_req || d_req) state_d = StAddr;
      StAddr:  if (m_rdy) state_d = StResp;
      StResp:  if (m_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, drop flag and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      drop_q  <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            owner   <= grant;
            drop_q  <= 1'b0;
            m_addr  <= grant ? d_addr : i_addr;
            m_we    <= grant & d_we;
            m_wdata <= grant ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= grant;
`endif
          end
        end
        StAddr: begin
          if (flush_hit) drop_q <= 1'b1;
        end
        StResp: begin
          if (flush_hit) drop_q <= 1'b1;
          if (m_valid) begin
            if (owner) begin
              d_valid <= 1'b1;
              d_rdata <= m_rdata;
            end else if (!(drop_q || i_flush)) begin
              // A flush arriving with the response also discards it
              i_valid <= 1'b1;
              i_rdata <= m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
